// File: rtl/dmem_arbiter_if.sv
// Bundle between the two requesters, the single-port data RAM and dmem_arbiter.
// master = environment side (core, loader, RAM); slave = the arbiter itself.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              p0_req;
  logic [MASK_W-1:0] p0_wmask;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic [MASK_W-1:0] p1_wmask;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_lock;

  logic              ram_en;
  logic [MASK_W-1:0] ram_wmask;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output p0_req, p0_wmask, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_wmask, p1_addr, p1_wdata, p1_lock,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  ram_en, ram_wmask, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  p0_req, p0_wmask, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_wmask, p1_addr, p1_wdata, p1_lock,
    output p1_gnt, p1_rvalid, p1_rdata,
    output ram_en, ram_wmask, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for one single-port data RAM; grant is combinational, rvalid one cycle after a granted read.
// Losers must hold/retry their request while gnt is low; port 1 may lock the bus; starvation guard forces port 1.
// DMEM_ARB_RR_EN selects round-robin contention instead of fixed port-0 priority.
module dmem_arbiter #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           resetn,
  dmem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_LOCK1 = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_p0_rvalid;
  logic             r_p1_rvalid;
  logic             w_p0_gnt;
  logic             w_p1_gnt;
  logic             w_starved;
  logic             w_p1_pref;

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));

`ifdef DMEM_ARB_RR_EN
  logic r_last_winner;

  // Reset value 1 (port 1) so port 0 takes the first contended cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_winner <= 1'b1;
    end else if (w_p0_gnt) begin
      r_last_winner <= 1'b0;
    end else if (w_p1_gnt) begin
      r_last_winner <= 1'b1;
    end
  end

  assign w_p1_pref = w_starved | ~r_last_winner;
`else
  assign w_p1_pref = w_starved;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:   if (w_p1_gnt && bus.p1_lock) w_state_nxt = ST_LOCK1;
      ST_LOCK1: if (!bus.p1_lock || !bus.p1_req) w_state_nxt = ST_ARB;
      default:  w_state_nxt = ST_ARB;
    endcase
  end

  // Grants are gated by resetn so nothing reaches the RAM while in reset.
  always_comb begin
    w_p0_gnt = 1'b0;
    w_p1_gnt = 1'b0;
    if (resetn) begin
      case (r_state)
        ST_ARB: begin
          if (bus.p0_req && bus.p1_req) begin
            w_p1_gnt = w_p1_pref;
            w_p0_gnt = ~w_p1_pref;
          end else begin
            w_p0_gnt = bus.p0_req;
            w_p1_gnt = bus.p1_req;
          end
        end
        ST_LOCK1: w_p1_gnt = bus.p1_req;
        default: begin
          w_p0_gnt = 1'b0;
          w_p1_gnt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (bus.p1_req && !w_p1_gnt) begin
      if (!w_starved) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
    end else begin
      r_p0_rvalid <= w_p0_gnt && (bus.p0_wmask == '0);
      r_p1_rvalid <= w_p1_gnt && (bus.p1_wmask == '0);
    end
  end

  assign bus.p0_gnt    = w_p0_gnt;
  assign bus.p1_gnt    = w_p1_gnt;
  assign bus.p0_rvalid = r_p0_rvalid;
  assign bus.p1_rvalid = r_p1_rvalid;
  // Both rdata ports see the RAM directly; only rvalid tells the owner apart.
  assign bus.p0_rdata  = resetn ? bus.ram_rdata : '0;
  assign bus.p1_rdata  = resetn ? bus.ram_rdata : '0;

  assign bus.ram_en    = w_p0_gnt | w_p1_gnt;
  assign bus.ram_wmask = w_p1_gnt ? bus.p1_wmask : (w_p0_gnt ? bus.p0_wmask : '0);
  assign bus.ram_addr  = w_p1_gnt ? bus.p1_addr  : (w_p0_gnt ? bus.p0_addr  : '0);
  assign bus.ram_wdata = w_p1_gnt ? bus.p1_wdata : (w_p0_gnt ? bus.p0_wdata : '0);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus task models the arbitration rules and a shadow memory,
// a separate monitor pops expected read returns when rvalid is due.
module tb_dmem_arbiter;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int SMAX   = 4;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // RAM model: registered read, byte-masked write, 64 words.
  logic [31:0] ram_mem [64];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_wmask == 4'b0000) begin
        bus.ram_rdata <= ram_mem[bus.ram_addr[7:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_wmask[b]) ram_mem[bus.ram_addr[7:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  exp_t sbq[$];
  logic [31:0] shadow [64];
  bit  m_locked;
  int  m_denied;
`ifdef DMEM_ARB_RR_EN
  bit  m_lw;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    sbq.delete();
    m_locked = 1'b0;
    m_denied = 0;
`ifdef DMEM_ARB_RR_EN
    m_lw = 1'b1;
`endif
  endtask

  // One bus cycle: drive, then check grants and RAM bus against the rules.
  task automatic drive(input bit r0, input logic [3:0] m0, input int w0, input logic [31:0] d0,
                       input bit r1, input logic [3:0] m1, input int w1, input logic [31:0] d1,
                       input bit lk);
    bit g0, g1, pref1;
    int widx;
    logic [3:0] m;
    logic [31:0] d;
    exp_t e;
    @(posedge clk);
    #1;
    bus.p0_req = r0; bus.p0_wmask = m0; bus.p0_addr = ADDR_W'(w0 * 4); bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_wmask = m1; bus.p1_addr = ADDR_W'(w1 * 4); bus.p1_wdata = d1;
    bus.p1_lock = lk;
    #1;
    if (m_locked) begin
      g0 = 1'b0; g1 = r1;
    end else if (r0 && r1) begin
      pref1 = (m_denied == SMAX);
`ifdef DMEM_ARB_RR_EN
      if (!m_lw) pref1 = 1'b1;
`endif
      g1 = pref1; g0 = !pref1;
    end else begin
      g0 = r0; g1 = r1;
    end
    chk1("p0_gnt", bus.p0_gnt, g0);
    chk1("p1_gnt", bus.p1_gnt, g1);
    if (g0 || g1) begin
      widx = g1 ? w1 : w0;
      m    = g1 ? m1 : m0;
      d    = g1 ? d1 : d0;
      chk1("ram_en", bus.ram_en, 1'b1);
      chk32("ram_addr", 32'(bus.ram_addr), 32'(widx * 4));
      chk32("ram_wmask", 32'(bus.ram_wmask), 32'(m));
      chk32("ram_wdata", bus.ram_wdata, d);
      if (m == 4'b0000) begin
        e.port = g1 ? 1 : 0;
        e.data = shadow[widx];
        e.due  = cyc + 1;
        sbq.push_back(e);
      end else begin
        for (int b = 0; b < 4; b++)
          if (m[b]) shadow[widx][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      chk1("ram_en_idle", bus.ram_en, 1'b0);
      chk32("ram_addr_idle", 32'(bus.ram_addr), 32'h0);
      chk32("ram_wmask_idle", 32'(bus.ram_wmask), 32'h0);
    end
    m_denied = (r1 && !g1) ? ((m_denied < SMAX) ? m_denied + 1 : SMAX) : 0;
    m_locked = m_locked ? (r1 && lk) : (g1 && lk);
`ifdef DMEM_ARB_RR_EN
    if (g0) m_lw = 1'b0;
    else if (g1) m_lw = 1'b1;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 4'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0, 0);
  endtask

  task automatic set_idle_inputs();
    bus.p0_req = 1'b0; bus.p0_wmask = 4'h0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_wmask = 4'h0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.p1_lock = 1'b0;
  endtask

  // Async reset in mid-cycle with the last requests still applied.
  task automatic do_reset();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk1("rst_p0_rvalid", bus.p0_rvalid, 1'b0);
    chk1("rst_p1_rvalid", bus.p1_rvalid, 1'b0);
    chk1("rst_ram_en", bus.ram_en, 1'b0);
    chk1("rst_p0_gnt", bus.p0_gnt, 1'b0);
    chk1("rst_p1_gnt", bus.p1_gnt, 1'b0);
    set_idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  // Monitor: every cycle, rvalid must match exactly the read due now.
  initial begin
    exp_t e;
    bit x0, x1;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) continue;
      x0 = 1'b0; x1 = 1'b0;
      e.port = -1; e.data = '0; e.due = 0;
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e  = sbq.pop_front();
        x0 = (e.port == 0);
        x1 = (e.port == 1);
      end
      chk1("p0_rvalid", bus.p0_rvalid, x0);
      chk1("p1_rvalid", bus.p1_rvalid, x1);
      if (x0) chk32("p0_rdata", bus.p0_rdata, e.data);
      if (x1) chk32("p1_rdata", bus.p1_rdata, e.data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    bit r0, r1, lk;
    logic [3:0] m0, m1;
    resetn = 1'b0;
    model_reset();
    set_idle_inputs();
    bus.p0_req = 1'b1;
    bus.p1_req = 1'b1;
    #3;
    chk1("reset_p0_gnt", bus.p0_gnt, 1'b0);
    chk1("reset_p1_gnt", bus.p1_gnt, 1'b0);
    chk1("reset_ram_en", bus.ram_en, 1'b0);
    chk1("reset_p0_rvalid", bus.p0_rvalid, 1'b0);
    chk1("reset_p1_rvalid", bus.p1_rvalid, 1'b0);
    chk32("reset_p0_rdata", bus.p0_rdata, 32'h0);
    set_idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;

    // Fill RAM through port 1; word 4 (byte 0x10) gets a known pattern.
    for (int i = 0; i < 64; i++)
      drive(0, 4'h0, 0, 32'h0, 1, 4'hF, i, (i == 4) ? 32'hDEADBEEF : $urandom, 0);
    idle(1);

    // Sole p0 read of 0x10.
    drive(1, 4'h0, 4, 32'h0, 0, 4'h0, 0, 32'h0, 0);
    idle(1);

    // Continuous contention: starvation override gives p1 every fifth cycle.
    for (int i = 0; i < 12; i++)
      drive(1, 4'h0, $urandom_range(0, 63), $urandom, 1, 4'h0, $urandom_range(0, 63), $urandom, 0);
    idle(1);

    // Locked p1 writes to 0x20 while p0 keeps requesting, then release.
    drive(0, 4'h0, 0, 32'h0, 1, 4'b0011, 8, 32'h0000ABCD, 1);
    drive(1, 4'h0, 5, 32'h0, 1, 4'b0011, 8, 32'h0000ABCD, 1);
    drive(1, 4'h0, 5, 32'h0, 1, 4'b0011, 8, 32'h0000ABCD, 1);
    drive(1, 4'h0, 8, 32'h0, 0, 4'h0, 0, 32'h0, 0);
    drive(1, 4'h0, 8, 32'h0, 0, 4'h0, 0, 32'h0, 0);
    idle(1);

    // Consecutive sole p1 reads of 0x0, 0x4, 0x8.
    drive(0, 4'h0, 0, 32'h0, 1, 4'h0, 0, 32'h0, 0);
    drive(0, 4'h0, 0, 32'h0, 1, 4'h0, 1, 32'h0, 0);
    drive(0, 4'h0, 0, 32'h0, 1, 4'h0, 2, 32'h0, 0);
    idle(1);

    // Reset right after a granted p0 read, then a sole p1 read.
    drive(1, 4'h0, 4, 32'h0, 0, 4'h0, 0, 32'h0, 0);
    do_reset();
    drive(0, 4'h0, 0, 32'h0, 1, 4'h0, 4, 32'h0, 0);
    idle(1);

    // Reset while locked must release the lock.
    drive(0, 4'h0, 0, 32'h0, 1, 4'hF, 9, 32'h12345678, 1);
    do_reset();
    drive(1, 4'h0, 9, 32'h0, 1, 4'h0, 3, 32'h0, 0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r0 = ($urandom_range(0, 9) < 6);
      r1 = ($urandom_range(0, 9) < 5);
      lk = ($urandom_range(0, 3) == 0);
      m0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      m1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      drive(r0, m0, $urandom_range(0, 63), $urandom, r1, m1, $urandom_range(0, 63), $urandom, lk);
    end
    idle(3);
    chk32("scoreboard_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
